usb_transmitter: RTL and testbench
==================================

Name: usb_transmitter

Overview:
Full-speed USB packet transmitter. It is the transmit-direction counterpart of usb_receiver.
- On a start request it serialises SYNC, the PID byte and N data bytes pulled from an external show-ahead TX FIFO.
- It applies bit stuffing and NRZI encoding, then drives EOP (SE0 x2, J x1) onto d_plus/d_minus.
- It sits between the protocol/DMA layer (which fills the TX FIFO) and the bus pad drivers.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit period (>=2)
MAX_BYTES, 64, maximum data payload bytes; sets the width of tx_packet_size (clog2(MAX_BYTES+1))

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tx_start  input  1  one-cycle request; sampled only when idle
tx_pid  input  4  PID nibble; sent on the wire as {~tx_pid, tx_pid}, LSB first
tx_packet_size  input  7  data byte count, 0..MAX_BYTES; latched with tx_start
tx_data  input  8  head byte of the TX FIFO (show-ahead)
tx_empty  input  1  TX FIFO empty flag
tx_data_get  output  1  one-cycle pop strobe to the TX FIFO
d_plus  output  1  bus D+
d_minus  output  1  bus D-
transmitting  output  1  high from accept of tx_start until end of EOP J bit
tx_done  output  1  one-cycle pulse after EOP completes
tx_error  output  1  sticky underflow flag; cleared on next accepted tx_start

Behaviour:
- Reset (asynchronous, any state): state=IDLE, d_plus=1, d_minus=0 (J), transmitting=0, tx_done=0, tx_error=0, tx_data_get=0, bit timer=0, stuff counter=0.
- Bit timer: counts 0..CLKS_PER_BIT-1 while not IDLE. The line changes only when count=0 (bit boundary). The counter is held at 0 in IDLE.
- Accept:
  - tx_start=1 in IDLE latches tx_pid and tx_packet_size, and clears tx_error.
  - The next cycle the state enters SYNC, transmitting=1, and the first bit is driven.
  - Latency from the tx_start cycle to the first line change is 1 clk.
  - tx_start outside IDLE is ignored.
- States and transitions:
  - IDLE -> SYNC on accept.
  - SYNC: 8 bits of 0x80, LSB first (0000000 then 1). SYNC -> PID.
  - PID: 8 bits of {~pid, pid}, LSB first. PID -> DATA if remaining>0, otherwise -> EOP_SE0.
  - DATA:
    - At the first bit boundary of each byte: if tx_empty=0, pulse tx_data_get for exactly that cycle, load tx_data into the shift register, and decrement remaining.
    - If tx_empty=1: set tx_error, do not pop, and go directly to EOP_SE0 (abort).
    - After the 8th bit of a byte: stay in DATA if remaining>0, otherwise -> EOP_SE0.
  - EOP_SE0: d_plus=0, d_minus=0 for 2 bit periods. EOP_SE0 -> EOP_J.
  - EOP_J: J for 1 bit period. EOP_J -> IDLE.
- Leaving EOP_J: transmitting falls and tx_done pulses in the same cycle as IDLE entry.
- NRZI encoding: a raw 0 toggles the line between J (1/0) and K (0/1); a raw 1 holds it. The encoder starts from J.
- Bit stuffing:
  - The counter counts consecutive raw 1s from the start of SYNC; the trailing SYNC 1 counts as 1.
  - The count runs across byte boundaries and resets on any raw 0.
  - After the 6th consecutive 1, the next bit period is an inserted 0 (a toggle), and the counter resets.
  - A stuffed bit does not advance the byte bit index.
  - A stuff bit due after the final data bit is still sent before EOP.
  - There is no stuffing during EOP.
- Zero-length packets (tx_packet_size=0, e.g. handshakes): no tx_data_get is ever asserted.
- Reset mid-packet: the lines return to J immediately, no tx_done is produced, and the TX FIFO is not popped further.

Decomposition:
- Shared package usb_pkg holds:
  - tx state enum: IDLE, SYNC, PID, DATA, EOP_SE0, EOP_J.
  - SYNC_BYTE=8'h80, STUFF_LIMIT=6, EOP_SE0_BITS=2.
  - PID constants: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, DATA1=4'b1011, ACK=4'b0010, NAK=4'b1010.
- One sub-module, tx_bit_timer: the CLKS_PER_BIT counter producing a bit_strobe. It is enabled while not IDLE.
- The FSM, shift register, stuff counter and NRZI register stay in usb_transmitter.

Test Plan:
- ACK, size=0, CLKS_PER_BIT=8 -> per-bit lines: SYNC K J K J K J K K; PID 0xD2 J J K J J K K K; then SE0 for 16 clks and J for 8 clks. tx_done pulses 152 clks after the first bit. tx_data_get is never asserted.
- DATA0, size=1, FIFO holds 0xFF -> one tx_data_get at the first DATA bit boundary. Exactly one stuffed 0 after the 4th data bit (run started with the 2 trailing PID 1s). Data field is 9 bit periods. tx_error=0.
- DATA1, size=3, FIFO holds only 2 bytes -> 2 pops, tx_error=1 at the 3rd byte boundary, immediate SE0 x2 then J, tx_done pulses. tx_error remains 1 until the next accepted tx_start.
- tx_start pulsed again during PID -> ignored; the packet bit stream is unchanged; exactly one tx_done.
- rst asserted mid-DATA -> d_plus=1, d_minus=0, transmitting=0 in the same cycle (asynchronous). No tx_done, no further pops. A subsequent ACK transmits correctly.
- OUT with 0x00 data, size=1 -> NRZI toggles every bit for all 8 data bits; no stuff bits in the data field.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: transmitter state encoding, framing constants and PID codes.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

  localparam logic [3:0] OUT   = 4'b0001;
  localparam logic [3:0] IN    = 4'b1001;
  localparam logic [3:0] DATA0 = 4'b0011;
  localparam logic [3:0] DATA1 = 4'b1011;
  localparam logic [3:0] ACK   = 4'b0010;
  localparam logic [3:0] NAK   = 4'b1010;

  // Wire form of a PID: check nibble (complement) in the upper half.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled; bit_strobe marks count 0.
module tx_bit_timer
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_strobe
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (!en) begin
      count_q <= '0;
    end else if (count_q == CW'(CLKS_PER_BIT - 1)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign bit_strobe = (count_q == '0);

endmodule

// File: rtl/usb_transmitter.sv
// Full-speed USB packet transmitter: SYNC, PID and FIFO payload, bit stuffed and
// NRZI encoded onto d_plus/d_minus, closed by SE0 x2 and J.
module usb_transmitter
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64,
  localparam int SIZE_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [3:0]        tx_pid,
  input  logic [SIZE_W-1:0] tx_packet_size,
  input  logic [7:0]        tx_data,
  input  logic              tx_empty,
  output logic              tx_data_get,
  output logic              d_plus,
  output logic              d_minus,
  output logic              transmitting,
  output logic              tx_done,
  output logic              tx_error
);

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  tx_state_t         state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        ones_q, ones_d;
  logic [SIZE_W-1:0] remaining_q, remaining_d;
  logic [3:0]        pid_q, pid_d;
  logic              nrzi_q, nrzi_d;
  logic [1:0]        line_q, line_d;
  logic              error_q, error_d;
  logic              done_q, done_d;

  logic       bit_strobe;
  logic       pop;
  logic       send;
  logic       raw;
  logic       load;
  logic [7:0] load_val;

  // Enabled by the next state so the accept edge already starts the first bit period.
  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (state_d != IDLE),
    .bit_strobe(bit_strobe)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      ones_q      <= '0;
      remaining_q <= '0;
      pid_q       <= '0;
      nrzi_q      <= 1'b1;
      line_q      <= LINE_J;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      ones_q      <= ones_d;
      remaining_q <= remaining_d;
      pid_q       <= pid_d;
      nrzi_q      <= nrzi_d;
      line_q      <= line_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every variable written here is given a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    ones_d      = ones_q;
    remaining_d = remaining_q;
    pid_d       = pid_q;
    nrzi_d      = nrzi_q;
    line_d      = line_q;
    error_d     = error_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    send        = 1'b0;
    raw         = 1'b0;
    load        = 1'b0;
    load_val    = '0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d     = SYNC;
          pid_d       = tx_pid;
          remaining_d = tx_packet_size;
          error_d     = 1'b0;
          load        = 1'b1;
          load_val    = SYNC_BYTE;
        end
      end

      SYNC, PID, DATA: begin
        if (bit_strobe) begin
          // A due stuff bit takes priority and leaves the byte position untouched.
          if (ones_q == 3'(STUFF_LIMIT)) begin
            send = 1'b1;
          end else if (idx_q != 3'd7) begin
            idx_d   = idx_q + 3'd1;
            shreg_d = shreg_q >> 1;
            send    = 1'b1;
            raw     = shreg_q[1];
          end else if (state_q == SYNC) begin
            state_d  = PID;
            load     = 1'b1;
            load_val = pid_byte(pid_q);
          end else if (remaining_q == '0) begin
            state_d = EOP_SE0;
            idx_d   = '0;
            line_d  = LINE_SE0;
          end else if (tx_empty) begin
            error_d = 1'b1;
            state_d = EOP_SE0;
            idx_d   = '0;
            line_d  = LINE_SE0;
          end else begin
            state_d     = DATA;
            pop         = 1'b1;
            remaining_d = remaining_q - SIZE_W'(1);
            load        = 1'b1;
            load_val    = tx_data;
          end
        end
      end

      EOP_SE0: begin
        if (bit_strobe) begin
          if (idx_q == 3'(EOP_SE0_BITS - 1)) begin
            state_d = EOP_J;
            line_d  = LINE_J;
            nrzi_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      EOP_J: begin
        if (bit_strobe) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d = load_val;
      idx_d   = '0;
      send    = 1'b1;
      raw     = load_val[0];
    end

    // NRZI: a raw 0 toggles the line, a raw 1 holds it.
    if (send) begin
      nrzi_d = raw ? nrzi_q : ~nrzi_q;
      ones_d = raw ? ones_q + 3'd1 : 3'd0;
      line_d = {nrzi_d, ~nrzi_d};
    end
  end

  assign tx_data_get  = pop;
  assign d_plus       = line_q[1];
  assign d_minus      = line_q[0];
  assign transmitting = (state_q != IDLE);
  assign tx_done      = done_q;
  assign tx_error     = error_q;

endmodule

// File: tb/tb_usb_transmitter.sv
// Self-checking bench for usb_transmitter: line symbols per bit period compared
// against a bit-stream model built from packet framing, stuffing and NRZI rules.
module tb_usb_transmitter;
  import usb_pkg::*;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] tx_packet_size;
  logic [7:0] tx_data  = 8'hA5;
  logic       tx_empty = 1'b1;
  logic       tx_data_get, d_plus, d_minus, transmitting, tx_done, tx_error;

  int checks = 0;
  int passed = 0;
  int pops = 0;
  int done_count = 0;

  logic [7:0] fifo[$];
  logic [1:0] exp_sym[$];
  int         exp_pops;
  bit         exp_err;
  bit         m_level;
  int         m_ones;

  usb_transmitter #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_start      (tx_start),
    .tx_pid        (tx_pid),
    .tx_packet_size(tx_packet_size),
    .tx_data       (tx_data),
    .tx_empty      (tx_empty),
    .tx_data_get   (tx_data_get),
    .d_plus        (d_plus),
    .d_minus       (d_minus),
    .transmitting  (transmitting),
    .tx_done       (tx_done),
    .tx_error      (tx_error)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head/empty refresh after each edge.
  always @(posedge clk) begin
    if (tx_data_get === 1'b1) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pops++;
    end
    tx_empty <= (fifo.size() == 0);
    tx_data  <= (fifo.size() > 0) ? fifo[0] : 8'hA5;
  end

  always @(posedge clk) if (tx_done === 1'b1) done_count++;

  // ---- reference model: raw bits -> stuffing -> NRZI symbols ({d+,d-}) ----
  task automatic emit_bit(input bit b);
    if (!b) m_level = ~m_level;
    exp_sym.push_back(m_level ? 2'b10 : 2'b01);
    m_ones = b ? m_ones + 1 : 0;
    if (m_ones == 6) begin
      m_level = ~m_level;
      exp_sym.push_back(m_level ? 2'b10 : 2'b01);
      m_ones = 0;
    end
  endtask

  task automatic emit_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) emit_bit(v[i]);
  endtask

  task automatic build_model(input logic [3:0] pid, input int size);
    exp_sym.delete();
    m_level  = 1'b1;
    m_ones   = 0;
    exp_pops = (fifo.size() < size) ? fifo.size() : size;
    exp_err  = (fifo.size() < size);
    emit_byte(8'h80);
    emit_byte({~pid, pid});
    for (int i = 0; i < exp_pops; i++) emit_byte(fifo[i]);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  // Sends one packet and checks every bit period, tx_done timing, pops and error.
  task automatic run_packet(input logic [3:0] pid, input int size, input string name,
                            input int inject_bit);
    int pops0, done0, n;
    build_model(pid, size);
    pops0 = pops;
    done0 = done_count;
    n     = exp_sym.size();
    @(negedge clk);
    tx_pid         = pid;
    tx_packet_size = 7'(size);
    tx_start       = 1'b1;
    @(negedge clk);
    tx_start       = 1'b0;
    tx_pid         = 4'($urandom);
    tx_packet_size = 7'($urandom);
    checks++;
    if (tx_error !== 1'b0) $display("FAIL %s_err_clear: got %b want 0", name, tx_error);
    else passed++;
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({d_plus, d_minus, transmitting, tx_done} !== {exp_sym[k], 2'b10})
        $display("FAIL %s_bit%0d: got dp/dm/tx/done=%b want %b", name, k,
                 {d_plus, d_minus, transmitting, tx_done}, {exp_sym[k], 2'b10});
      else passed++;
      if (k == inject_bit) begin
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (CPB - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    checks++;
    if ({d_plus, d_minus, transmitting, tx_done} !== 4'b1001)
      $display("FAIL %s_done_pulse: got dp/dm/tx/done=%b want 1001", name,
               {d_plus, d_minus, transmitting, tx_done});
    else passed++;
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) $display("FAIL %s_done_width: got %b want 0", name, tx_done);
    else passed++;
    checks++;
    if (pops - pops0 !== exp_pops)
      $display("FAIL %s_pops: got %0d want %0d", name, pops - pops0, exp_pops);
    else passed++;
    checks++;
    if (tx_error !== exp_err) $display("FAIL %s_error: got %b want %b", name, tx_error, exp_err);
    else passed++;
    checks++;
    if (done_count - done0 !== 1)
      $display("FAIL %s_done_count: got %0d want 1", name, done_count - done0);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({d_plus, d_minus, transmitting, tx_done, tx_error, tx_data_get} !== 6'b100000)
      $display("FAIL reset_outputs: got %b want 100000",
               {d_plus, d_minus, transmitting, tx_done, tx_error, tx_data_get});
    else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_plus, d_minus, transmitting} !== 3'b100)
      $display("FAIL reset_idle: got %b want 100", {d_plus, d_minus, transmitting});
    else passed++;
  endtask

  task automatic test_ack();
    fifo.delete();
    run_packet(ACK, 0, "ack", -1);
  endtask

  task automatic test_data0_stuff();
    fifo.delete();
    fifo.push_back(8'hFF);
    run_packet(DATA0, 1, "data0_ff", -1);
  endtask

  task automatic test_underflow();
    fifo.delete();
    fifo.push_back(8'h3C);
    fifo.push_back(8'hFF);
    run_packet(DATA1, 3, "underflow", -1);
    repeat (20) @(negedge clk);
    checks++;
    if (tx_error !== 1'b1) $display("FAIL underflow_sticky: got %b want 1", tx_error);
    else passed++;
  endtask

  task automatic test_ignore_start();
    fifo.delete();
    fifo.push_back(8'h81);
    run_packet(DATA1, 1, "ignore", 10);
  endtask

  task automatic test_reset_mid();
    int pops0, done0;
    fifo.delete();
    fifo.push_back(8'h5A);
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    fifo.push_back(8'h33);
    @(negedge clk);
    pops0 = pops;
    done0 = done_count;
    tx_pid = DATA0;
    tx_packet_size = 7'd4;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d_plus, d_minus, transmitting, tx_data_get} !== 4'b1000)
      $display("FAIL rst_mid_async: got dp/dm/tx/get=%b want 1000",
               {d_plus, d_minus, transmitting, tx_data_get});
    else passed++;
    checks++;
    if (pops - pops0 !== 1) $display("FAIL rst_mid_pops_before: got %0d want 1", pops - pops0);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    checks++;
    if (pops - pops0 !== 1) $display("FAIL rst_mid_pops_after: got %0d want 1", pops - pops0);
    else passed++;
    checks++;
    if (done_count !== done0) $display("FAIL rst_mid_no_done: got %0d want %0d", done_count, done0);
    else passed++;
    checks++;
    if ({d_plus, d_minus, transmitting} !== 3'b100)
      $display("FAIL rst_mid_idle: got %b want 100", {d_plus, d_minus, transmitting});
    else passed++;
    fifo.delete();
    @(negedge clk);
    run_packet(ACK, 0, "ack_after_rst", -1);
  endtask

  task automatic test_out_zero();
    fifo.delete();
    fifo.push_back(8'h00);
    run_packet(OUT, 1, "out_zero", -1);
  endtask

  task automatic test_random();
    logic [3:0] pids[6];
    pids = '{OUT, IN, DATA0, DATA1, ACK, NAK};
    for (int p = 0; p < 6; p++) begin
      int size, avail;
      size  = $urandom_range(0, 6);
      avail = (size > 0 && $urandom_range(0, 3) == 0) ? size - 1 : size;
      fifo.delete();
      for (int i = 0; i < avail; i++)
        fifo.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      @(negedge clk);
      run_packet(pids[$urandom_range(0, 5)], size, "rand", -1);
      fifo.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    tx_start       = 1'b0;
    tx_pid         = 4'h0;
    tx_packet_size = 7'd0;
    test_reset();
    test_ack();
    test_data0_stuff();
    test_underflow();
    test_out_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
